rf_wb_scoreboard: RTL and testbench
===================================

Name: rf_wb_scoreboard

Overview:
- Controller in front of the 32x32 register file: arbitrates ALU and LSU writeback onto the single write port and keeps a busy scoreboard of pending destinations.
- Stalls issue on RAW/WAW hazards, and in any cycle in which the register file is being written, because read data does not update in write cycles.
- Sits between the issue stage, the execute/LSU writeback paths and the register file.

Parameters:
- XLEN, 32, data width.
- STARVE_LIMIT, 3, consecutive ALU denials after which the ALU wins arbitration once (range 1..15).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- issue_valid  in  1  issue stage presents an instruction.
- issue_rd  in  5  destination register (0 = no writeback).
- issue_rs1  in  5  source register 1.
- issue_rs2  in  5  source register 2.
- issue_stall  out  1  combinational; instruction is not accepted this cycle.
- alu_wb_valid  in  1  ALU writeback request.
- alu_wb_rd  in  5  ALU destination.
- alu_wb_data  in  XLEN  ALU result.
- alu_wb_ready  out  1  combinational grant to the ALU.
- lsu_wb_valid  in  1  LSU writeback request.
- lsu_wb_rd  in  5  LSU destination.
- lsu_wb_data  in  XLEN  load data.
- lsu_wb_ready  out  1  combinational grant to the LSU.
- rf_write_en  out  1  registered; to register file.
- rf_write_reg  out  5  registered.
- rf_write_data  out  XLEN  registered.
- busy_vec  out  32  scoreboard state; bit 0 is always 0.

Behaviour:
- Reset (rst=0, asynchronous): busy_vec=0, rf_write_en=0, rf_write_reg=0, rf_write_data=0, starvation counter=0. Any in-flight writeback is dropped; requesters re-present after reset.
- Issue acceptance: accepted = issue_valid & ~issue_stall.
- issue_stall = issue_valid & (rf_write_en | (rs1!=0 & busy[rs1]) | (rs2!=0 & busy[rs2]) | (rd!=0 & busy[rd])).
- On an accepted issue with rd!=0, busy[rd] sets at the next edge.
- Arbitration (combinational):
  - Only one valid: that requester is granted.
  - Both valid: LSU granted, unless starve_cnt == STARVE_LIMIT, in which case ALU is granted.
  - A handshake completes when valid & ready in the same cycle.
  - Requesters hold rd/data stable while valid and not ready.
- Starvation counter:
  - Increments when both are valid and the ALU is denied.
  - Clears on any ALU grant, or when alu_wb_valid=0.
  - Saturates at STARVE_LIMIT.
- Write pipeline, one cycle of latency. On the edge after a grant:
  - rf_write_en <= (granted rd != 0).
  - rf_write_reg <= granted rd.
  - rf_write_data <= granted data.
  - busy[granted rd] <= 0.
- With no grant, rf_write_en <= 0; rf_write_reg and rf_write_data hold.
- Grant with rd=0: the handshake completes, rf_write_en stays 0, and no stall is induced.
- Simultaneous set/clear of the same busy bit (writeback to a non-busy rd while the issue sets it): set wins.
- Writeback to a register that is not busy: the write happens and busy is unchanged (apart from the set-wins rule).
- busy[0] is never set.
- Back-to-back grants produce consecutive rf_write_en pulses. issue_stall stays high for every cycle rf_write_en=1.
- Reset asserted mid-operation clears all state immediately. Outputs are valid from the first clk edge after rst deasserts.

Test Plan:
- Reset → busy_vec=0, rf_write_en=0; issue rd=5, rs1=1, rs2=2 → accepted; next cycle busy_vec=32'h20.
- RAW hazard: busy[5]=1; issue rs1=5 → issue_stall=1. ALU writeback rd=5, data=32'hDEAD → alu_wb_ready=1; next cycle rf_write_en=1, reg=5, data=32'hDEAD, busy[5]=0, issue_stall=1. Following cycle issue_stall=0.
- Contention: ALU and LSU both held valid, STARVE_LIMIT=3 → grant order LSU, LSU, LSU, ALU, LSU…; rf_write_en high every cycle.
- rd=0: issue rd=0 → busy unchanged; LSU writeback rd=0 → lsu_wb_ready=1, rf_write_en stays 0.
- WAW: busy[7]=1; issue rd=7 → stall until the writeback to 7 completes and rf_write_en drops.
- Reset mid-operation: assert rst=0 while busy_vec=32'h0000_00A0 and rf_write_en=1 → both cleared asynchronously, before the next clock edge.

Source files
------------

// File: rtl/rf_wb_scoreboard_if.sv
// Handshake bundle between the issue stage, the ALU/LSU writeback paths and the
// register-file writeback controller.
interface rf_wb_scoreboard_if #(
    parameter int XLEN = 32
);
    logic            issue_valid;
    logic [4:0]      issue_rd;
    logic [4:0]      issue_rs1;
    logic [4:0]      issue_rs2;
    logic            issue_stall;

    logic            alu_wb_valid;
    logic [4:0]      alu_wb_rd;
    logic [XLEN-1:0] alu_wb_data;
    logic            alu_wb_ready;

    logic            lsu_wb_valid;
    logic [4:0]      lsu_wb_rd;
    logic [XLEN-1:0] lsu_wb_data;
    logic            lsu_wb_ready;

    logic            rf_write_en;
    logic [4:0]      rf_write_reg;
    logic [XLEN-1:0] rf_write_data;
    logic [31:0]     busy_vec;

    modport master (
        output issue_valid, issue_rd, issue_rs1, issue_rs2,
        output alu_wb_valid, alu_wb_rd, alu_wb_data,
        output lsu_wb_valid, lsu_wb_rd, lsu_wb_data,
        input  issue_stall, alu_wb_ready, lsu_wb_ready,
        input  rf_write_en, rf_write_reg, rf_write_data, busy_vec
    );

    modport slave (
        input  issue_valid, issue_rd, issue_rs1, issue_rs2,
        input  alu_wb_valid, alu_wb_rd, alu_wb_data,
        input  lsu_wb_valid, lsu_wb_rd, lsu_wb_data,
        output issue_stall, alu_wb_ready, lsu_wb_ready,
        output rf_write_en, rf_write_reg, rf_write_data, busy_vec
    );
endinterface

// File: rtl/rf_wb_scoreboard.sv
// Writeback arbiter and busy scoreboard in front of the 32x32 register file:
// LSU-priority arbitration with ALU anti-starvation, RAW/WAW issue stalling.
module rf_wb_scoreboard #(
    parameter int XLEN         = 32,
    parameter int STARVE_LIMIT = 3
) (
    input logic               clk,
    input logic               rst,
    rf_wb_scoreboard_if.slave bus
);
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [31:0]     busy_q;
    logic [31:0]     busy_nxt;
    logic [3:0]      starve_cnt;
    logic            alu_grant;
    logic            lsu_grant;
    logic            any_grant;
    logic [4:0]      g_rd;
    logic [XLEN-1:0] g_data;
    logic            issue_acc;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        alu_grant = bus.alu_wb_valid & (~bus.lsu_wb_valid | (starve_cnt == LIMIT));
        lsu_grant = bus.lsu_wb_valid & ~alu_grant;
        any_grant = alu_grant | lsu_grant;
        g_rd      = bus.lsu_wb_rd;
        g_data    = bus.lsu_wb_data;
        if (alu_grant) begin
            g_rd   = bus.alu_wb_rd;
            g_data = bus.alu_wb_data;
        end
    end

    assign bus.alu_wb_ready = alu_grant;
    assign bus.lsu_wb_ready = lsu_grant;

    // Read data is stale while the register file is being written, so stall then too.
    assign bus.issue_stall = bus.issue_valid & (bus.rf_write_en
                           | ((bus.issue_rs1 != 5'd0) & busy_q[bus.issue_rs1])
                           | ((bus.issue_rs2 != 5'd0) & busy_q[bus.issue_rs2])
                           | ((bus.issue_rd  != 5'd0) & busy_q[bus.issue_rd]));

    assign issue_acc = bus.issue_valid & ~bus.issue_stall;

    // Clear is applied before set so a same-cycle issue to the same rd wins.
    always_comb begin
        busy_nxt = busy_q;
        if (any_grant) busy_nxt[g_rd] = 1'b0;
        if (issue_acc && bus.issue_rd != 5'd0) busy_nxt[bus.issue_rd] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q            <= '0;
            starve_cnt        <= '0;
            bus.rf_write_en   <= 1'b0;
            bus.rf_write_reg  <= '0;
            bus.rf_write_data <= '0;
        end else begin
            busy_q          <= busy_nxt;
            bus.rf_write_en <= any_grant & (g_rd != 5'd0);
            if (any_grant) begin
                bus.rf_write_reg  <= g_rd;
                bus.rf_write_data <= g_data;
            end
            if (!bus.alu_wb_valid || alu_grant) begin
                starve_cnt <= '0;
            end else if (starve_cnt != LIMIT) begin
                starve_cnt <= starve_cnt + 4'd1;
            end
        end
    end

    assign bus.busy_vec = busy_q;
endmodule

// File: tb/tb_rf_wb_scoreboard.sv
// Directed bench: stimulus pushes expected register-file writes into a queue,
// a negedge monitor pops and compares whenever rf_write_en is seen.
module tb_rf_wb_scoreboard;
    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad = 0;
    wr_t  exp_q[$];

    rf_wb_scoreboard_if #(.XLEN(32)) sif ();

    rf_wb_scoreboard #(.XLEN(32), .STARVE_LIMIT(3)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (sif)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [4:0] rd, input logic [31:0] data);
        wr_t w;
        w.rd   = rd;
        w.data = data;
        exp_q.push_back(w);
    endtask

    task automatic issue(input logic v, input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        sif.issue_valid = v;
        sif.issue_rd    = rd;
        sif.issue_rs1   = rs1;
        sif.issue_rs2   = rs2;
    endtask

    task automatic alu(input logic v, input logic [4:0] rd, input logic [31:0] d);
        sif.alu_wb_valid = v;
        sif.alu_wb_rd    = rd;
        sif.alu_wb_data  = d;
    endtask

    task automatic lsu(input logic v, input logic [4:0] rd, input logic [31:0] d);
        sif.lsu_wb_valid = v;
        sif.lsu_wb_rd    = rd;
        sif.lsu_wb_data  = d;
    endtask

    // Monitor: every write pulse must match the oldest expected write
    initial begin
        wr_t w;
        forever begin
            @(negedge clk);
            if (rst && sif.rf_write_en) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write_reg", 64'(sif.rf_write_reg), 64'h0);
                    check("unexpected_write_en", 64'(sif.rf_write_en), 64'h0);
                end else begin
                    w = exp_q.pop_front();
                    check("wb_reg", 64'(sif.rf_write_reg), 64'(w.rd));
                    check("wb_data", 64'(sif.rf_write_data), 64'(w.data));
                end
            end
        end
    end

    initial begin
        logic [4:0] grant_alu;
        int alu_n;
        int lsu_n;
        issue(1'b0, 5'd0, 5'd0, 5'd0);
        alu(1'b0, 5'd0, 32'h0);
        lsu(1'b0, 5'd0, 32'h0);

        // Reset state, then first issue
        #12;
        check("reset_busy", 64'(sif.busy_vec), 64'h0);
        check("reset_wr_en", 64'(sif.rf_write_en), 64'h0);
        rst = 1'b1;
        next();
        issue(1'b1, 5'd5, 5'd1, 5'd2);
        sample();
        check("first_issue_stall", 64'(sif.issue_stall), 64'h0);
        next();
        issue(1'b0, 5'd0, 5'd0, 5'd0);
        check("busy_after_issue", 64'(sif.busy_vec), 64'h20);

        // RAW hazard on r5, resolved by ALU writeback
        issue(1'b1, 5'd6, 5'd5, 5'd0);
        alu(1'b1, 5'd5, 32'hDEAD);
        sample();
        check("raw_stall", 64'(sif.issue_stall), 64'h1);
        check("raw_alu_ready", 64'(sif.alu_wb_ready), 64'h1);
        push(5'd5, 32'hDEAD);
        next();
        alu(1'b0, 5'd0, 32'h0);
        sample();
        check("raw_wr_en", 64'(sif.rf_write_en), 64'h1);
        check("raw_busy5_clear", 64'(sif.busy_vec[5]), 64'h0);
        check("raw_stall_write_cycle", 64'(sif.issue_stall), 64'h1);
        next();
        sample();
        check("raw_stall_released", 64'(sif.issue_stall), 64'h0);
        next();
        issue(1'b0, 5'd0, 5'd0, 5'd0);
        check("busy_r6", 64'(sif.busy_vec), 64'h40);

        // Contention: LSU, LSU, LSU, ALU, LSU
        grant_alu = 5'b01000;
        alu_n = 0;
        lsu_n = 0;
        for (int i = 0; i < 5; i++) begin
            alu(1'b1, 5'd10, 32'hA000_0000 + 32'(alu_n));
            lsu(1'b1, 5'd11, 32'h1000_0000 + 32'(lsu_n));
            sample();
            check($sformatf("cont_alu_ready_%0d", i), 64'(sif.alu_wb_ready), 64'(grant_alu[i]));
            check($sformatf("cont_lsu_ready_%0d", i), 64'(sif.lsu_wb_ready), 64'(!grant_alu[i]));
            if (i > 0) check($sformatf("cont_wr_en_%0d", i), 64'(sif.rf_write_en), 64'h1);
            if (grant_alu[i]) push(5'd10, 32'hA000_0000 + 32'(alu_n));
            else              push(5'd11, 32'h1000_0000 + 32'(lsu_n));
            next();
            if (grant_alu[i]) alu_n++;
            else              lsu_n++;
        end
        alu(1'b0, 5'd0, 32'h0);
        lsu(1'b0, 5'd0, 32'h0);
        sample();
        check("cont_last_wr_en", 64'(sif.rf_write_en), 64'h1);
        next();

        // rd = 0: no busy bit, no write pulse, no stall
        issue(1'b1, 5'd0, 5'd0, 5'd0);
        sample();
        check("rd0_issue_stall", 64'(sif.issue_stall), 64'h0);
        next();
        issue(1'b0, 5'd0, 5'd0, 5'd0);
        check("rd0_busy", 64'(sif.busy_vec), 64'h40);
        lsu(1'b1, 5'd0, 32'h1234);
        sample();
        check("rd0_lsu_ready", 64'(sif.lsu_wb_ready), 64'h1);
        next();
        lsu(1'b0, 5'd0, 32'h0);
        issue(1'b1, 5'd0, 5'd1, 5'd0);
        sample();
        check("rd0_wr_en", 64'(sif.rf_write_en), 64'h0);
        check("rd0_no_stall", 64'(sif.issue_stall), 64'h0);
        next();

        // WAW on r7
        issue(1'b1, 5'd7, 5'd0, 5'd0);
        next();
        check("waw_busy", 64'(sif.busy_vec), 64'hC0);
        sample();
        check("waw_stall_0", 64'(sif.issue_stall), 64'h1);
        next();
        sample();
        check("waw_stall_1", 64'(sif.issue_stall), 64'h1);
        next();
        alu(1'b1, 5'd7, 32'h77);
        sample();
        check("waw_alu_ready", 64'(sif.alu_wb_ready), 64'h1);
        check("waw_stall_2", 64'(sif.issue_stall), 64'h1);
        push(5'd7, 32'h77);
        next();
        alu(1'b0, 5'd0, 32'h0);
        sample();
        check("waw_stall_write", 64'(sif.issue_stall), 64'h1);
        check("waw_busy7_clear", 64'(sif.busy_vec[7]), 64'h0);
        next();
        sample();
        check("waw_stall_release", 64'(sif.issue_stall), 64'h0);
        next();
        issue(1'b0, 5'd0, 5'd0, 5'd0);
        check("waw_reissued", 64'(sif.busy_vec), 64'hC0);

        // Retire r6 and mark r5 busy to reach 0xA0
        alu(1'b1, 5'd6, 32'h66);
        push(5'd6, 32'h66);
        next();
        alu(1'b0, 5'd0, 32'h0);
        next();
        issue(1'b1, 5'd5, 5'd0, 5'd0);
        next();
        issue(1'b0, 5'd0, 5'd0, 5'd0);
        check("busy_a0", 64'(sif.busy_vec), 64'hA0);

        // Asynchronous reset mid-operation
        lsu(1'b1, 5'd3, 32'h33);
        push(5'd3, 32'h33);
        next();
        lsu(1'b0, 5'd0, 32'h0);
        sample();
        #1;
        check("pre_rst_wr_en", 64'(sif.rf_write_en), 64'h1);
        check("pre_rst_busy", 64'(sif.busy_vec), 64'hA0);
        rst = 1'b0;
        #1;
        check("async_rst_wr_en", 64'(sif.rf_write_en), 64'h0);
        check("async_rst_busy", 64'(sif.busy_vec), 64'h0);
        check("async_rst_reg", 64'(sif.rf_write_reg), 64'h0);
        check("async_rst_data", 64'(sif.rf_write_data), 64'h0);
        next();
        rst = 1'b1;
        next();

        // Same-cycle issue and writeback to non-busy r9: set wins
        issue(1'b1, 5'd9, 5'd0, 5'd0);
        alu(1'b1, 5'd9, 32'h99);
        sample();
        check("setwin_stall", 64'(sif.issue_stall), 64'h0);
        push(5'd9, 32'h99);
        next();
        issue(1'b0, 5'd0, 5'd0, 5'd0);
        alu(1'b0, 5'd0, 32'h0);
        check("setwin_busy", 64'(sif.busy_vec), 64'h200);
        next();
        next();

        check("queue_drained", 64'(exp_q.size()), 64'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
